// File: rtl/cjtag_pkg.sv
// +----------------------------------------------------------------------+
// | cjtag_pkg                                                              |
// | Shared types and constants for the cJTAG-to-JTAG bridge and its TAP.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package cjtag_pkg;

  typedef enum logic [1:0] {
    BR_OFFLINE = 2'd0,
    BR_OAC     = 2'd1,
    BR_ONLINE  = 2'd2
  } bridge_state_t;

  typedef enum logic [3:0] {
    TAP_TEST_LOGIC_RESET = 4'd0,
    TAP_RUN_TEST_IDLE    = 4'd1,
    TAP_SELECT_DR        = 4'd2,
    TAP_CAPTURE_DR       = 4'd3,
    TAP_SHIFT_DR         = 4'd4,
    TAP_EXIT1_DR         = 4'd5,
    TAP_PAUSE_DR         = 4'd6,
    TAP_EXIT2_DR         = 4'd7,
    TAP_UPDATE_DR        = 4'd8,
    TAP_SELECT_IR        = 4'd9,
    TAP_CAPTURE_IR       = 4'd10,
    TAP_SHIFT_IR         = 4'd11,
    TAP_EXIT1_IR         = 4'd12,
    TAP_PAUSE_IR         = 4'd13,
    TAP_EXIT2_IR         = 4'd14,
    TAP_UPDATE_IR        = 4'd15
  } tap_state_t;

  localparam logic [3:0] c_oac_code       = 4'hC;
  localparam logic [3:0] c_ec_code        = 4'h8;
  localparam logic [3:0] c_cp_code        = 4'h0;

  localparam logic [3:0] c_esc_deselect   = 4'd4;
  localparam logic [3:0] c_esc_activate   = 4'd6;
  localparam logic [3:0] c_esc_reset      = 4'd8;

  localparam logic [4:0] c_instr_idcode   = 5'h01;
  localparam logic [4:0] c_instr_bypass   = 5'h1F;
  localparam logic [4:0] c_ir_capture_val = 5'b00001;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_TEST_LOGIC_RESET;
    case (s)
      TAP_TEST_LOGIC_RESET: n = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    n = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR:        n = tms ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       n = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         n = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         n = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         n = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         n = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        n = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      TAP_SELECT_IR:        n = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       n = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         n = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         n = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         n = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         n = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        n = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      default:              n = TAP_TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tap.sv
// +----------------------------------------------------------------------+
// | jtag_tap                                                               |
// | 1149.1 TAP with IDCODE and BYPASS, oversampling TCK on the system clk. |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module jtag_tap
  import cjtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1DEAD3FF,
  parameter int unsigned IR_LEN = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o
);

  localparam logic [IR_LEN-1:0] c_ir_idcode  = IR_LEN'(c_instr_idcode);
  localparam logic [IR_LEN-1:0] c_ir_bypass  = IR_LEN'(c_instr_bypass);
  localparam logic [IR_LEN-1:0] c_ir_capture = IR_LEN'(c_ir_capture_val);

  tap_state_t        r_state;
  tap_state_t        w_state_next;
  logic              r_tck_d;
  logic [IR_LEN-1:0] r_ir;
  logic [IR_LEN-1:0] r_ir_sr;
  logic [31:0]       r_dr;
  logic              r_bypass;
  logic              r_tdo;
  logic              w_tck_rise;
  logic              w_tck_fall;
  logic              w_sel_bypass;
  logic              w_tdo_next;

  assign w_tck_rise   = tck_i & ~r_tck_d;
  assign w_tck_fall   = ~tck_i & r_tck_d;
  assign w_sel_bypass = (r_ir == c_ir_bypass) || (r_ir != c_ir_idcode);
  assign tdo_o        = r_tdo;

  always_comb begin
    w_state_next = tap_next(r_state, tms_i);
  end

  always_comb begin
    w_tdo_next = 1'b0;
    case (r_state)
      TAP_SHIFT_DR: w_tdo_next = w_sel_bypass ? r_bypass : r_dr[0];
      TAP_SHIFT_IR: w_tdo_next = r_ir_sr[0];
      default:      w_tdo_next = 1'b0;
    endcase
  end

  // Register actions use the state held before the TCK rise, as in 1149.1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tck_d  <= 1'b0;
      r_state  <= TAP_TEST_LOGIC_RESET;
      r_ir     <= c_ir_idcode;
      r_ir_sr  <= c_ir_capture;
      r_dr     <= 32'd0;
      r_bypass <= 1'b0;
      r_tdo    <= 1'b0;
    end else begin
      r_tck_d <= tck_i;
      if (w_tck_rise) begin
        r_state <= w_state_next;
        case (r_state)
          TAP_TEST_LOGIC_RESET: r_ir <= c_ir_idcode;
          TAP_CAPTURE_DR: begin
            r_dr     <= IDCODE;
            r_bypass <= 1'b0;
          end
          TAP_SHIFT_DR: begin
            r_dr     <= {tdi_i, r_dr[31:1]};
            r_bypass <= tdi_i;
          end
          TAP_CAPTURE_IR: r_ir_sr <= c_ir_capture;
          TAP_SHIFT_IR:   r_ir_sr <= {tdi_i, r_ir_sr[IR_LEN-1:1]};
          TAP_UPDATE_IR:  r_ir    <= r_ir_sr;
          default: ;
        endcase
      end
      if (w_tck_fall) begin
        r_tdo <= w_tdo_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cjtag_jtag_bridge.sv
// +----------------------------------------------------------------------+
// | cjtag_jtag_bridge                                                      |
// | 2-wire cJTAG (OScan1) to 4-wire JTAG bridge with an internal TAP.      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module cjtag_jtag_bridge
  import cjtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1DEAD3FF,
  parameter int unsigned IR_LEN = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tckc_i,
  input  logic tmsc_i,
  output logic tmsc_o,
  output logic tmsc_oen,
  output logic tck_o,
  output logic tms_o,
  output logic tdi_o,
  output logic tdo_o,
  output logic online_o,
  output logic nsp_o
);

  bridge_state_t r_state;
  bridge_state_t w_state_next;
  logic [1:0]    r_tckc_sync;
  logic [1:0]    r_tmsc_sync;
  logic          r_tckc_d;
  logic          r_tmsc_d;
  logic [3:0]    r_esc_cnt;
  logic [11:0]   r_oac_sr;
  logic [3:0]    r_oac_cnt;
  logic [1:0]    r_slot;
  logic          r_tck;
  logic          r_tms;
  logic          r_tdi;
  logic          r_tmsc_o;
  logic          r_oen;

  logic w_tckc, w_tmsc, w_rise, w_fall, w_tmsc_edge;
  logic w_esc_any, w_esc_desel, w_esc_act, w_esc_reset, w_oac_match;

  assign w_tckc      = r_tckc_sync[1];
  assign w_tmsc      = r_tmsc_sync[1];
  assign w_rise      = w_tckc & ~r_tckc_d;
  assign w_fall      = ~w_tckc & r_tckc_d;
  assign w_tmsc_edge = w_tmsc ^ r_tmsc_d;

  assign w_esc_reset = w_fall && (r_esc_cnt >= c_esc_reset);
  assign w_esc_any   = w_fall && (r_esc_cnt >= c_esc_deselect);
  assign w_esc_act   = w_fall && (r_esc_cnt >= c_esc_activate) && (r_esc_cnt < c_esc_reset);
  assign w_esc_desel = w_fall && (r_esc_cnt >= c_esc_deselect) && (r_esc_cnt < c_esc_activate);
  assign w_oac_match = (r_oac_sr == {c_cp_code, c_ec_code, c_oac_code});

  assign online_o = (r_state == BR_ONLINE);
  assign nsp_o    = ~online_o;
  assign tck_o    = r_tck;
  assign tms_o    = r_tms;
  assign tdi_o    = r_tdi;
  assign tmsc_o   = r_tmsc_o;
  assign tmsc_oen = r_oen;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BR_OFFLINE: if (w_esc_act) w_state_next = BR_OAC;
      // The OAC word is judged on the fall that closes the 12th bit.
      BR_OAC: if (w_fall && (r_oac_cnt == 4'd12))
                w_state_next = w_oac_match ? BR_ONLINE : BR_OFFLINE;
      BR_ONLINE:  if (w_esc_desel) w_state_next = BR_OFFLINE;
      default:    w_state_next = BR_OFFLINE;
    endcase
    if (w_esc_reset) w_state_next = BR_OFFLINE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= BR_OFFLINE;
      r_tckc_sync <= 2'b00;
      r_tmsc_sync <= 2'b00;
      r_tckc_d    <= 1'b0;
      r_tmsc_d    <= 1'b0;
      r_esc_cnt   <= 4'd0;
      r_oac_sr    <= 12'd0;
      r_oac_cnt   <= 4'd0;
      r_slot      <= 2'd0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_tmsc_o    <= 1'b0;
      r_oen       <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_tckc_sync <= {r_tckc_sync[0], tckc_i};
      r_tmsc_sync <= {r_tmsc_sync[0], tmsc_i};
      r_tckc_d    <= w_tckc;
      r_tmsc_d    <= w_tmsc;

      // Our own drive on TMSC must not look like escape edges.
      if (w_fall) begin
        r_esc_cnt <= 4'd0;
      end else if (w_tckc && r_oen && w_tmsc_edge && (r_esc_cnt != 4'd15)) begin
        r_esc_cnt <= r_esc_cnt + 4'd1;
      end

      if (r_state != BR_OAC) begin
        r_oac_cnt <= 4'd0;
      end else if (w_rise && (r_oac_cnt != 4'd12)) begin
        r_oac_sr  <= {w_tmsc, r_oac_sr[11:1]};
        r_oac_cnt <= r_oac_cnt + 4'd1;
      end

      if (r_state != BR_ONLINE) begin
        r_slot <= 2'd0;
        r_tck  <= 1'b0;
        r_oen  <= 1'b1;
      end else if (w_esc_any) begin
        r_slot <= 2'd0;
        r_tck  <= 1'b0;
        r_oen  <= 1'b1;
      end else begin
        if (w_rise) begin
          case (r_slot)
            2'd0:    r_tdi <= ~w_tmsc;
            2'd1:    r_tms <= w_tmsc;
            2'd2:    r_tck <= 1'b1;
            default: ;
          endcase
        end
        if (w_fall) begin
          case (r_slot)
            2'd1: begin
              r_oen    <= 1'b0;
              r_tmsc_o <= tdo_o;
            end
            2'd2: begin
              r_tck <= 1'b0;
              r_oen <= 1'b1;
            end
            default: ;
          endcase
          r_slot <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
        end
      end
    end
  end

  jtag_tap #(
    .IDCODE (IDCODE),
    .IR_LEN (IR_LEN)
  ) u_tap (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tck_i (r_tck),
    .tms_i (r_tms),
    .tdi_i (r_tdi),
    .tdo_o (tdo_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_cjtag_jtag_bridge.sv
// +----------------------------------------------------------------------+
// | tb_cjtag_jtag_bridge                                                   |
// | Randomized scoreboard bench against a JTAG-level reference model.      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cjtag_jtag_bridge;
  import cjtag_pkg::*;

  localparam logic [31:0] IDC = 32'h1DEAD3FF;

  logic clk = 1'b0;
  logic rst_i, tckc_i, tmsc_i;
  logic tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, tdo_o, online_o, nsp_o;

  cjtag_jtag_bridge #(.IDCODE(IDC), .IR_LEN(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .tckc_i(tckc_i), .tmsc_i(tmsc_i),
    .tmsc_o(tmsc_o), .tmsc_oen(tmsc_oen), .tck_o(tck_o), .tms_o(tms_o),
    .tdi_o(tdi_o), .tdo_o(tdo_o), .online_o(online_o), .nsp_o(nsp_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // Reference TAP: state index and 1149.1 transition tables.
  localparam int S_TLR = 0, S_SHDR = 4, S_CAPDR = 3, S_CAPIR = 10, S_SHIR = 11, S_UPIR = 15;
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int m_state;
  int m_ir;
  bit m_dr[$];
  bit m_irq[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = S_TLR;
    m_ir    = 1;
    m_dr.delete();
    m_irq.delete();
    exp_q.delete();
  endfunction

  // Returns the TDO the probe should see for this bit, then applies one TCK.
  function automatic bit model_step(bit tms, bit tdi);
    bit o;
    o = 1'b0;
    if (m_state == S_SHDR && m_dr.size() > 0) o = m_dr[0];
    if (m_state == S_SHIR && m_irq.size() > 0) o = m_irq[0];
    case (m_state)
      S_TLR: m_ir = 1;
      S_CAPDR: begin
        m_dr.delete();
        if (m_ir == 1) for (int i = 0; i < 32; i++) m_dr.push_back(IDC[i]);
        else m_dr.push_back(1'b0);
      end
      S_SHDR: begin
        if (m_dr.size() > 0) void'(m_dr.pop_front());
        m_dr.push_back(tdi);
      end
      S_CAPIR: begin
        m_irq.delete();
        for (int i = 0; i < 5; i++) m_irq.push_back(i == 0);
      end
      S_SHIR: begin
        if (m_irq.size() > 0) void'(m_irq.pop_front());
        m_irq.push_back(tdi);
      end
      S_UPIR: begin
        m_ir = 0;
        for (int i = 0; i < m_irq.size(); i++) if (m_irq[i]) m_ir += (1 << i);
      end
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    return o;
  endfunction

  // Scoreboard monitor: each assertion of the TMSC driver carries one TDO bit.
  logic mon_prev_oen = 1'b1;
  bit   mon_e;
  always @(negedge clk) begin
    if (mon_prev_oen && !tmsc_oen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tdo_unexpected: got %0b expected no drive at %0t", tmsc_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("tdo_read", tmsc_o, mon_e);
      end
    end
    mon_prev_oen = tmsc_oen;
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cbit(bit d);
    wait_cyc(2);
    tmsc_i = d;
    wait_cyc($urandom_range(4, 6));
    tckc_i = 1'b1;
    wait_cyc($urandom_range(4, 6));
    tckc_i = 1'b0;
  endtask

  task automatic escape(int n);
    wait_cyc(2);
    tckc_i = 1'b1;
    wait_cyc(4);
    repeat (n) begin
      tmsc_i = ~tmsc_i;
      wait_cyc(3);
    end
    wait_cyc(2);
    tckc_i = 1'b0;
    wait_cyc(4);
  endtask

  task automatic send_oac(int flip);
    bit [11:0] v;
    v = 12'h08C;
    if (flip >= 0) v[flip] = ~v[flip];
    for (int i = 0; i < 12; i++) cbit(v[i]);
    wait_cyc(4);
  endtask

  task automatic jtag_bit(bit tms, bit tdi);
    exp_q.push_back(model_step(tms, tdi));
    cbit(~tdi);
    wait_cyc(2);
    tmsc_i = tms;
    wait_cyc($urandom_range(4, 6));
    tckc_i = 1'b1;
    wait_cyc($urandom_range(4, 6));
    check("oen_slot1_high", tmsc_oen, 1'b1);
    tckc_i = 1'b0;
    wait_cyc($urandom_range(6, 8));
    tckc_i = 1'b1;
    wait_cyc($urandom_range(4, 6));
    check("oen_slot2_high", tmsc_oen, 1'b0);
    check("tck_slot2_high", tck_o, 1'b1);
    tckc_i = 1'b0;
  endtask

  task automatic shift_ir(logic [4:0] v);
    jtag_bit(1, 0); jtag_bit(1, 0); jtag_bit(0, 0); jtag_bit(0, 0);
    for (int i = 0; i < 5; i++) jtag_bit(i == 4, v[i]);
    jtag_bit(1, 0); jtag_bit(0, 0);
  endtask

  task automatic shift_dr(int n, logic [63:0] data);
    jtag_bit(1, 0); jtag_bit(0, 0); jtag_bit(0, 0);
    for (int i = 0; i < n; i++) jtag_bit(i == n - 1, data[i]);
    jtag_bit(1, 0); jtag_bit(0, 0);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_online"}, online_o, 1'b0);
    check({tag, "_nsp"}, nsp_o, 1'b1);
    check({tag, "_oen"}, tmsc_oen, 1'b1);
    check({tag, "_tck"}, tck_o, 1'b0);
    check({tag, "_tms"}, tms_o, 1'b1);
    check({tag, "_tdi"}, tdi_o, 1'b0);
    check({tag, "_tmsc_o"}, tmsc_o, 1'b0);
    check({tag, "_tdo"}, tdo_o, 1'b0);
  endtask

  initial begin
    logic [63:0] rnd;
    rst_i = 1'b1; tckc_i = 1'b0; tmsc_i = 1'b0;
    model_reset();
    wait_cyc(4);
    check_reset_values("reset");
    rst_i = 1'b0;
    wait_cyc(3);

    // Short escape: no activation, OAC bits afterwards are ignored.
    escape(2);
    send_oac(-1);
    check("esc2_online", online_o, 1'b0);

    // Corrupted OAC words fall back to OFFLINE.
    repeat (3) begin
      escape($urandom_range(6, 7));
      send_oac($urandom_range(0, 11));
      check("bad_oac_online", online_o, 1'b0);
      check("bad_oac_nsp", nsp_o, 1'b1);
    end

    // Reset escape (including saturating counts) in OAC returns to OFFLINE.
    escape(6);
    for (int i = 0; i < 4; i++) cbit(i[0]);
    escape($urandom_range(8, 20));
    send_oac(-1);
    check("esc_reset_in_oac", online_o, 1'b0);

    escape(7);
    send_oac(-1);
    check("activate_online", online_o, 1'b1);
    check("activate_nsp", nsp_o, 1'b0);

    repeat (5) jtag_bit(1, 1'($urandom_range(0, 1)));
    jtag_bit(0, 0);
    rnd = {$urandom, $urandom};
    shift_dr(32, rnd);

    shift_ir(c_instr_bypass);
    shift_dr(3, 64'b101);

    repeat (4) begin
      if ($urandom_range(0, 1) == 1) shift_ir(c_instr_idcode);
      else shift_ir(5'($urandom_range(0, 31)));
      rnd = {$urandom, $urandom};
      shift_dr($urandom_range(1, 40), rnd);
    end

    escape($urandom_range(4, 5));
    check("deselect_online", online_o, 1'b0);
    check("deselect_tck", tck_o, 1'b0);
    check("deselect_oen", tmsc_oen, 1'b1);

    escape(6);
    send_oac(-1);
    check("reactivate_online", online_o, 1'b1);
    shift_ir(c_instr_idcode);

    // Part-way through SHIFT_DR, then reset in the middle of a triplet.
    jtag_bit(1, 0); jtag_bit(0, 0); jtag_bit(0, 0);
    repeat (3) jtag_bit(0, 1'($urandom_range(0, 1)));
    wait_cyc(2);
    tmsc_i = 1'b1;
    wait_cyc(5);
    tckc_i = 1'b1;
    wait_cyc(3);
    #3;
    rst_i = 1'b1;
    #1;
    check_reset_values("async_reset");
    tckc_i = 1'b0;
    tmsc_i = 1'b0;
    model_reset();
    wait_cyc(3);
    rst_i = 1'b0;
    wait_cyc(3);

    escape(7);
    send_oac(-1);
    check("post_reset_online", online_o, 1'b1);
    jtag_bit(0, 0);
    rnd = {$urandom, $urandom};
    shift_dr(32, rnd);

    wait_cyc(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
